// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// A circular buffer of DEPTH entries, each holding {order, pc, inst}.
// Pops are answered one cycle later through a registered instr_data/pop_resp pair.
// Flush and reset both empty the queue and cancel any pop response.
module instr_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [31:0]  push_inst,
  input  logic [31:0]  push_pc,
  input  logic [63:0]  push_order,
  output logic         full,
  input  logic         instr_q_pop,
  output logic [127:0] instr_data,
  output logic         pop_resp,
  input  logic         flush,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // Occupancy flags come straight from the count.  Full is judged before
  // any same-cycle pop, so a push against a full queue is always dropped.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = instr_q_pop && !empty && !flush;

  // Entry storage; contents are never cleared because count guards every read.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[tail] <= {push_order, push_pc, push_inst};
    end
  end

  // Pointers, occupancy and the registered pop response.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pop_resp   <= 1'b0;
      instr_data <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pop_resp <= 1'b0;
    end else begin
      pop_resp <= pop_ok;
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (pop_ok) begin
        head       <= head + 1'b1;
        instr_data <= mem[head];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH = 16).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_instr_queue;

  localparam int DEPTH = 16;

  logic         clk;
  logic         rst;
  logic         push;
  logic [31:0]  push_inst;
  logic [31:0]  push_pc;
  logic [63:0]  push_order;
  logic         full;
  logic         instr_q_pop;
  logic [127:0] instr_data;
  logic         pop_resp;
  logic         flush;
  logic         empty;

  int n_compared   = 0;
  int n_mismatched = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_inst  (push_inst),
    .push_pc    (push_pc),
    .push_order (push_order),
    .full       (full),
    .instr_q_pop(instr_q_pop),
    .instr_data (instr_data),
    .pop_resp   (pop_resp),
    .flush      (flush),
    .empty      (empty)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected packed entry for a given order tag; inst and pc are derived from it.
  function automatic logic [127:0] mk(input int o);
    logic [31:0] inst;
    logic [31:0] pc;
    inst = 32'h0000_1000 + 32'(o);
    pc   = 32'h8000_0000 + 32'(o) * 32'd4;
    return {64'(o), pc, inst};
  endfunction

  task automatic applyStimulus(input logic p, input int o, input logic pp, input logic f);
    logic [127:0] e;
    e           = mk(o);
    push        = p;
    push_inst   = e[31:0];
    push_pc     = e[63:32];
    push_order  = e[127:64];
    instr_q_pop = pp;
    flush       = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [127:0] last_data;
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_pop_resp", 128'(pop_resp), 128'd0);
    checkOutput("reset_data", instr_data, 128'd0);
    checkOutput("reset_empty", 128'(empty), 128'd1);
    checkOutput("reset_full", 128'(full), 128'd0);
    rst = 1'b0;

    // Basic push then pop with the literal entry.
    push = 1'b1; push_inst = 32'h0000_0013; push_pc = 32'h6000_0000; push_order = 64'd0;
    instr_q_pop = 1'b0; flush = 1'b0;
    tick();
    checkOutput("one_entry_not_empty", 128'(empty), 128'd0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("basic_pop_resp", 128'(pop_resp), 128'd1);
    checkOutput("basic_pop_data", instr_data, 128'h0000000000000000_60000000_00000013);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();
    checkOutput("basic_resp_one_cycle", 128'(pop_resp), 128'd0);
    checkOutput("basic_empty_after", 128'(empty), 128'd1);

    // Pop on empty leaves instr_data alone.
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("empty_pop_resp", 128'(pop_resp), 128'd0);
    checkOutput("empty_pop_data_held", instr_data, 128'h0000000000000000_60000000_00000013);

    // No bypass: push and pop together on an empty queue.
    applyStimulus(1'b1, 7, 1'b1, 1'b0);
    tick();
    checkOutput("nobypass_resp", 128'(pop_resp), 128'd0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("nobypass_late_resp", 128'(pop_resp), 128'd1);
    checkOutput("nobypass_late_data", instr_data, mk(7));
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();

    // Fill to DEPTH, drop one extra push, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, i, 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill_full", 128'(full), 128'd1);
    applyStimulus(1'b1, 16, 1'b0, 1'b0);
    tick();
    checkOutput("overflow_still_full", 128'(full), 128'd1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("drain_resp_%0d", i), 128'(pop_resp), 128'd1);
      checkOutput($sformatf("drain_data_%0d", i), instr_data, mk(i));
    end
    checkOutput("drain_empty", 128'(empty), 128'd1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_extra_pop_resp", 128'(pop_resp), 128'd0);

    // Streaming push+pop for 40 cycles after one prefill.
    applyStimulus(1'b1, 100, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 101 + k, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stream_resp_%0d", k), 128'(pop_resp), 128'd1);
      checkOutput($sformatf("stream_data_%0d", k), instr_data, mk(100 + k));
      checkOutput($sformatf("stream_occ_%0d", k), 128'({empty, full}), 128'd0);
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_tail_data", instr_data, mk(140));
    checkOutput("stream_tail_empty", 128'(empty), 128'd1);

    // Flush with push and pop while holding 5 entries.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 200 + i, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 205, 1'b1, 1'b1);
    tick();
    checkOutput("flush_empty", 128'(empty), 128'd1);
    checkOutput("flush_resp", 128'(pop_resp), 128'd0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("flush_nothing_stored", 128'(pop_resp), 128'd0);
    applyStimulus(1'b1, 206, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("postflush_data", instr_data, mk(206));

    // Flush cancels the cycle after an in-flight pop response.
    applyStimulus(1'b1, 210, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 211, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    checkOutput("inflight_resp", 128'(pop_resp), 128'd1);
    checkOutput("inflight_data", instr_data, mk(210));
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    tick();
    checkOutput("inflight_flushed_resp", 128'(pop_resp), 128'd0);
    checkOutput("inflight_flushed_empty", 128'(empty), 128'd1);

    // Full queue with simultaneous push and pop: push dropped.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 300 + i, 1'b0, 1'b0);
      tick();
    end
    checkOutput("full2_full", 128'(full), 128'd1);
    applyStimulus(1'b1, 316, 1'b1, 1'b0);
    tick();
    checkOutput("full_pp_resp", 128'(pop_resp), 128'd1);
    checkOutput("full_pp_data", instr_data, mk(300));
    checkOutput("full_pp_not_full", 128'(full), 128'd0);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("full_pp_drain_%0d", i), instr_data, mk(300 + i));
    end
    checkOutput("full_pp_drained_empty", 128'(empty), 128'd1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();

    // Reset mid-operation kills the pending pop response.
    applyStimulus(1'b1, 400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("midreset_resp", 128'(pop_resp), 128'd0);
    checkOutput("midreset_data", instr_data, 128'd0);
    checkOutput("midreset_empty", 128'(empty), 128'd1);
    rst = 1'b0;
    last_data = instr_data;
    tick();
    checkOutput("postreset_resp", 128'(pop_resp), 128'd0);
    checkOutput("postreset_data", instr_data, last_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 push  input  1  fetch offers one instruction this cycle.
REQ-005 push_inst  input  32  instruction word.
REQ-006 push_pc  input  32  instruction PC.
REQ-007 push_order  input  64  instruction order tag.
REQ-008 full  output  1  no free entry; combinational from occupancy count.
REQ-009 instr_q_pop  input  1  decode requests one entry.
REQ-010 instr_data  output  128  popped entry, packed as {order[127:64], pc[63:32], inst[31:0]}; registered.
REQ-011 pop_resp  output  1  instr_data holds a valid popped entry this cycle; registered.
REQ-012 flush  input  1  discard all contents.
REQ-013 empty  output  1  occupancy zero; combinational from count.

Function
REQ-014 Storage: circular buffer of DEPTH x 128 bits; head (read) and tail (write) pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
REQ-015 full = (count == DEPTH); empty = (count == 0).
REQ-016 Push accepted iff push && !full && !flush; entry {push_order, push_pc, push_inst} written at tail; tail increments modulo DEPTH.
REQ-017 Push while full (and no accepted pop the same cycle) is dropped; no overwrite; state unchanged.
REQ-018 Pop accepted iff instr_q_pop && !empty && !flush; head entry is registered into instr_data; pop_resp=1 in the next cycle; head increments modulo DEPTH.
REQ-019 Latency: 1 cycle from accepted pop to pop_resp high; sustained 1 pop per cycle with pop_resp high on consecutive cycles.
REQ-020 Pop while empty: pop_resp=0 next cycle; instr_data holds its previous value.
REQ-021 pop_resp is high for exactly one cycle per accepted pop; it is 0 in any cycle following a non-accepted pop.
REQ-022 Simultaneous accepted push and pop: count unchanged; both pointers advance.
REQ-023 Push to an empty queue is not visible to a pop in the same cycle (no bypass); the earliest pop_resp is 2 cycles after the push.
REQ-024 Full with simultaneous pop and push: full is evaluated before the pop, so the push is dropped; only the pop is taken.
REQ-025 Pointer wrap: an index of DEPTH-1 advances to 0; FIFO order is preserved across the wrap.
REQ-026 Flush (priority over push and pop): head=tail=0 and count=0 at the next edge; pop_resp=0 next cycle; any in-flight pop_resp cycle already high is not extended.
REQ-027 count changes by at most ±1 per cycle; it never exceeds DEPTH and never underflows.

Reset
REQ-028 While rst is high at an edge: head=0, tail=0, count=0, pop_resp=0, instr_data=0; push, pop and flush are ignored.
REQ-029 After reset: full=0, empty=1; storage contents need not be cleared.
REQ-030 Reset mid-operation discards all entries, including a pending pop response; the first cycle after reset has pop_resp=0.

Verification
REQ-031 Reset, push inst=0x00000013, pc=0x60000000, order=0, then pop in the next cycle -> one cycle later pop_resp=1, instr_data=0x0000000000000000_60000000_00000013.
REQ-032 DEPTH=16: 16 pushes with no pops -> full=1; 17th push (order=16) dropped; 16 pops return order 0..15 in sequence, each with pop_resp=1; after that empty=1.
REQ-033 Continuous push and pop for 40 cycles, starting after 1 prefill -> count constant at 1; pop_resp high every cycle; orders returned strictly increasing through two pointer wraps.
REQ-034 Pop on empty queue -> pop_resp=0 next cycle; instr_data unchanged from its last value.
REQ-035 5 entries queued; assert flush together with push and pop -> next cycle count=0, empty=1, pop_resp=0; the pushed entry is not stored.
REQ-036 Full queue with push and pop in the same cycle -> the pop returns the oldest entry; the push is dropped; count=DEPTH-1 and full=0.
